// File: rtl/gba_rom_read_ctrl_pkg.sv
// Shared types and constants for the GBA Game Pak ROM burst-read controller.
// Holds the FSM state set, the default strobe timing, the stream beat payload and the bank-end test.
package gba_rom_read_ctrl_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned TMR_W  = 8;

    localparam int unsigned DEF_SETUP_CYC = 2;
    localparam int unsigned DEF_RD_CYC    = 4;
    localparam int unsigned DEF_HIGH_CYC  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_LATCH  = 3'd2,
        ST_TURN   = 3'd3,
        ST_RD     = 3'd4,
        ST_HOLD   = 3'd5,
        ST_FINISH = 3'd6
    } state_e;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } rd_beat_t;

    // The cartridge only auto-increments the low 16 address bits, so crossing FFFF needs a re-latch.
    function automatic logic is_bank_end(input logic [15:0] addr_lo);
        return addr_lo == 16'hFFFF;
    endfunction

endpackage

// File: rtl/gba_rom_read_ctrl_if.sv
// Host-side request and read-stream bundle of the ROM burst-read controller.
// master = host bridge, slave = controller.
interface gba_rom_read_ctrl_if;
    import gba_rom_read_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              busy;

    modport master (
        output req_valid, req_addr, req_len, rd_ready,
        input  req_ready, rd_valid, rd_data, rd_last, busy
    );

    modport slave (
        input  req_valid, req_addr, req_len, rd_ready,
        output req_ready, rd_valid, rd_data, rd_last, busy
    );

endinterface

// File: rtl/gba_rom_read_ctrl_wait_timer.sv
// Loadable down-counter with a zero flag; times the address setup, nRD low and nRD high dwells.
// The counter parks at zero until reloaded.
module gba_rom_read_ctrl_wait_timer
    import gba_rom_read_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    output logic             o_zero_c
);

    logic [TMR_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - TMR_W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/gba_rom_read_ctrl.sv
// Sequences Game Pak ROM burst reads over the multiplexed AD bus and streams captured halfwords.
// Every pin and stream output is a flop whose next value is decoded from the next FSM state.
module gba_rom_read_ctrl
    import gba_rom_read_ctrl_pkg::*;
#(
    parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
    parameter int unsigned RD_CYC    = DEF_RD_CYC,
    parameter int unsigned HIGH_CYC  = DEF_HIGH_CYC
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    gba_rom_read_ctrl_if.slave        bus,
    output logic                      o_cart_clk,
    output logic                      o_nwr,
    output logic                      o_ncs2,
    output logic                      o_ncs,
    output logic                      o_nrd,
    output logic                      o_add_dat_en,
    output logic [ADDR_W-1:0]         o_add_dat,
    input  logic [DATA_W-1:0]         i_data_read
);

    localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] RD_LD    = TMR_W'(RD_CYC - 1);
    localparam logic [TMR_W-1:0] HIGH_LD  = TMR_W'(HIGH_CYC - 1);

    state_e             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_remaining;
    rd_beat_t           r_beat;
    logic               r_rd_valid;
    logic               r_req_ready;
    logic               r_busy;
    logic               r_ncs;
    logic               r_nrd;
    logic               r_add_dat_en;
    logic [ADDR_W-1:0]  r_add_dat;
    logic               r_cart_clk;
    logic               r_nwr;
    logic               r_ncs2;

    state_e             w_state_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [LEN_W-1:0]   w_remaining_nxt;
    rd_beat_t           w_beat_nxt;
    logic               w_rd_valid_nxt;
    logic               w_req_ready_nxt;
    logic               w_busy_nxt;
    logic               w_ncs_nxt;
    logic               w_nrd_nxt;
    logic               w_add_dat_en_nxt;
    logic [ADDR_W-1:0]  w_add_dat_nxt;
    logic               w_tmr_load;
    logic [TMR_W-1:0]   w_tmr_val;
    logic               w_tmr_zero;
    logic               w_beat_free;

    gba_rom_read_ctrl_wait_timer u_wait_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero_c   (w_tmr_zero)
    );

    // The held beat is free once it is gone or being taken this cycle.
    assign w_beat_free = !r_rd_valid || bus.rd_ready;

    // Next-state, datapath and output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_remaining_nxt = r_remaining;
        w_beat_nxt      = r_beat;
        w_rd_valid_nxt  = r_rd_valid && !bus.rd_ready;
        w_tmr_load      = 1'b0;
        w_tmr_val       = '0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.req_valid && r_req_ready) begin
                    w_addr_nxt      = bus.req_addr;
                    w_remaining_nxt = bus.req_len;
                    w_state_nxt     = ST_ADDR;
                    w_tmr_load      = 1'b1;
                    w_tmr_val       = SETUP_LD;
                end
            end
            ST_ADDR: begin
                if (w_tmr_zero) begin
                    w_state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                w_state_nxt = ST_TURN;
            end
            ST_TURN: begin
                w_state_nxt = ST_RD;
                w_tmr_load  = 1'b1;
                w_tmr_val   = RD_LD;
            end
            ST_RD: begin
                if (w_tmr_zero) begin
                    w_beat_nxt.data = i_data_read;
                    w_beat_nxt.last = (r_remaining == '0);
                    w_rd_valid_nxt  = 1'b1;
                    w_state_nxt     = ST_HOLD;
                    w_tmr_load      = 1'b1;
                    w_tmr_val       = HIGH_LD;
                end
            end
            ST_HOLD: begin
                // nRD stays high here while the consumer stalls, so the cartridge address does not move.
                if (w_tmr_zero && w_beat_free) begin
                    if (r_remaining == '0) begin
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_addr_nxt      = r_addr + ADDR_W'(1);
                        w_remaining_nxt = r_remaining - LEN_W'(1);
                        w_tmr_load      = 1'b1;
                        if (is_bank_end(r_addr[15:0])) begin
                            w_state_nxt = ST_ADDR;
                            w_tmr_val   = SETUP_LD;
                        end else begin
                            w_state_nxt = ST_RD;
                            w_tmr_val   = RD_LD;
                        end
                    end
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_req_ready_nxt  = (w_state_nxt == ST_IDLE);
        w_busy_nxt       = (w_state_nxt != ST_IDLE);
        w_ncs_nxt        = !((w_state_nxt == ST_LATCH) || (w_state_nxt == ST_TURN) ||
                             (w_state_nxt == ST_RD)    || (w_state_nxt == ST_HOLD));
        w_nrd_nxt        = (w_state_nxt != ST_RD);
        w_add_dat_en_nxt = (w_state_nxt == ST_ADDR) || (w_state_nxt == ST_LATCH);
        w_add_dat_nxt    = (w_state_nxt == ST_ADDR) ? w_addr_nxt : r_add_dat;
    end

    // State and registered outputs; reset releases the bus and deasserts every strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_beat       <= '0;
            r_rd_valid   <= 1'b0;
            r_req_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_ncs        <= 1'b1;
            r_nrd        <= 1'b1;
            r_add_dat_en <= 1'b0;
            r_add_dat    <= '0;
            r_cart_clk   <= 1'b0;
            r_nwr        <= 1'b1;
            r_ncs2       <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_remaining  <= w_remaining_nxt;
            r_beat       <= w_beat_nxt;
            r_rd_valid   <= w_rd_valid_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_busy       <= w_busy_nxt;
            r_ncs        <= w_ncs_nxt;
            r_nrd        <= w_nrd_nxt;
            r_add_dat_en <= w_add_dat_en_nxt;
            r_add_dat    <= w_add_dat_nxt;
            r_cart_clk   <= 1'b0;
            r_nwr        <= 1'b1;
            r_ncs2       <= 1'b1;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_beat.data;
    assign bus.rd_last   = r_beat.last;
    assign bus.busy      = r_busy;

    assign o_cart_clk    = r_cart_clk;
    assign o_nwr         = r_nwr;
    assign o_ncs2        = r_ncs2;
    assign o_ncs         = r_ncs;
    assign o_nrd         = r_nrd;
    assign o_add_dat_en  = r_add_dat_en;
    assign o_add_dat     = r_add_dat;

endmodule
